// File: rtl/muxkey_table.sv
// muxkey_table: run-time programmable key/value table with a registered lookup port.
// Latency is one cycle for lookups and modifies; there is no back-pressure, and an insert into a full table is dropped with a wr_drop pulse.
module muxkey_table #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 8,
  localparam int CNT_W   = $clog2(NR_KEY + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  output logic                wr_drop,
  input  logic                del_en,
  input  logic [KEY_LEN-1:0]  del_key,
  input  logic                lk_valid,
  input  logic [KEY_LEN-1:0]  lk_key,
  input  logic [DATA_LEN-1:0] lk_default,
  output logic                out_valid,
  output logic                out_hit,
  output logic [DATA_LEN-1:0] out_data,
  output logic [CNT_W-1:0]    count,
  output logic                full
);

  localparam int IDX_W = $clog2(NR_KEY);

  logic [NR_KEY-1:0]   r_valid;
  logic [KEY_LEN-1:0]  r_key  [NR_KEY];
  logic [DATA_LEN-1:0] r_data [NR_KEY];
  logic [CNT_W-1:0]    r_count;
  logic                r_full;
  logic                r_drop;
  logic                r_out_valid;
  logic                r_out_hit;
  logic [DATA_LEN-1:0] r_out_data;

  logic                w_wr_hit, w_del_hit, w_lk_hit, w_has_free;
  logic [IDX_W-1:0]    w_wr_idx, w_del_idx, w_free_idx;
  logic [DATA_LEN-1:0] w_lk_data;

  logic [NR_KEY-1:0]   w_valid_nxt;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                w_drop;
  logic                w_we;
  logic [IDX_W-1:0]    w_we_idx;

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    w_wr_hit   = 1'b0;
    w_wr_idx   = '0;
    w_del_hit  = 1'b0;
    w_del_idx  = '0;
    w_lk_hit   = 1'b0;
    w_lk_data  = '0;
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_valid[i] && r_key[i] == wr_key) begin
        w_wr_hit = 1'b1;
        w_wr_idx = IDX_W'(i);
      end
      if (r_valid[i] && r_key[i] == del_key) begin
        w_del_hit = 1'b1;
        w_del_idx = IDX_W'(i);
      end
      if (r_valid[i] && r_key[i] == lk_key) begin
        w_lk_hit  = 1'b1;
        w_lk_data = r_data[i];
      end
    end
  end

  always_comb begin
    w_valid_nxt = r_valid;
    w_count_nxt = r_count;
    w_drop      = 1'b0;
    w_we        = 1'b0;
    w_we_idx    = w_wr_idx;
    if (clr) begin
      w_valid_nxt = '0;
      w_count_nxt = '0;
    end else if (wr_en) begin
      if (w_wr_hit) begin
        w_we = 1'b1;
      end else if (w_has_free) begin
        w_we                  = 1'b1;
        w_we_idx              = w_free_idx;
        w_valid_nxt[w_free_idx] = 1'b1;
        w_count_nxt           = r_count + CNT_W'(1);
      end else begin
        w_drop = 1'b1;
      end
    end else if (del_en && w_del_hit) begin
      w_valid_nxt[w_del_idx] = 1'b0;
      w_count_nxt            = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(NR_KEY));
      r_drop  <= w_drop;
    end
  end

  // Key/data storage is qualified by r_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_key[w_we_idx]  <= wr_key;
      r_data[w_we_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_hit   <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= lk_valid;
      if (lk_valid) begin
        r_out_hit  <= w_lk_hit;
        r_out_data <= w_lk_hit ? w_lk_data : lk_default;
      end
    end
  end

  assign wr_drop   = r_drop;
  assign out_valid = r_out_valid;
  assign out_hit   = r_out_hit;
  assign out_data  = r_out_data;
  assign count     = r_count;
  assign full      = r_full;

endmodule

// File: tb/tb_muxkey_table.sv
// Scoreboard bench for muxkey_table: directed scenarios plus random traffic
// checked against an associative-array model of the table.
module tb_muxkey_table;

  logic       clk, rst, clr, wr_en, del_en, lk_valid;
  logic [3:0] wr_key, del_key, lk_key;
  logic [7:0] wr_data, lk_default;
  logic       wr_drop, out_valid, out_hit, full;
  logic [7:0] out_data;
  logic [2:0] count;

  muxkey_table #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data), .wr_drop(wr_drop),
    .del_en(del_en), .del_key(del_key),
    .lk_valid(lk_valid), .lk_key(lk_key), .lk_default(lk_default),
    .out_valid(out_valid), .out_hit(out_hit), .out_data(out_data),
    .count(count), .full(full)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] model [int];
  logic [8:0] exp_q [$];
  logic [8:0] last_exp = '0;
  int         exp_count = 0;
  logic       exp_full  = 1'b0;
  logic       exp_drop  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops a lookup result whenever out_valid is seen.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          last_exp = exp_q.pop_front();
          chk("out_hit", {31'd0, out_hit}, {31'd0, last_exp[8]});
          chk("out_data", {24'd0, out_data}, {24'd0, last_exp[7:0]});
        end
      end else begin
        chk("hold_hit", {31'd0, out_hit}, {31'd0, last_exp[8]});
        chk("hold_data", {24'd0, out_data}, {24'd0, last_exp[7:0]});
      end
      chk("count", {29'd0, count}, exp_count);
      chk("full", {31'd0, full}, {31'd0, exp_full});
      chk("wr_drop", {31'd0, wr_drop}, {31'd0, exp_drop});
    end
  end

  task automatic idle_inputs();
    clr = 0; wr_en = 0; wr_key = 0; wr_data = 0; del_en = 0; del_key = 0;
    lk_valid = 0; lk_key = 0; lk_default = 0;
  endtask

  // One clock of stimulus; the model reads the table before the edge and updates after it.
  task automatic step(input logic c, input logic we, input logic [3:0] wk, input logic [7:0] wd,
                      input logic de, input logic [3:0] dk,
                      input logic lv, input logic [3:0] lk, input logic [7:0] ld);
    logic drop;
    clr = c; wr_en = we; wr_key = wk; wr_data = wd; del_en = de; del_key = dk;
    lk_valid = lv; lk_key = lk; lk_default = ld;
    if (lv) begin
      if (model.exists(int'(lk))) exp_q.push_back({1'b1, model[int'(lk)]});
      else                        exp_q.push_back({1'b0, ld});
    end
    @(posedge clk);
    drop = 1'b0;
    if (c) begin
      model.delete();
    end else if (we) begin
      if (model.exists(int'(wk)) || model.num() < 4) model[int'(wk)] = wd;
      else drop = 1'b1;
    end else if (de) begin
      if (model.exists(int'(dk))) model.delete(int'(dk));
    end
    exp_count = model.num();
    exp_full  = (model.num() == 4);
    exp_drop  = drop;
    #1;
    idle_inputs();
  endtask

  task automatic wr(input logic [3:0] k, input logic [7:0] d);
    step(0, 1, k, d, 0, 0, 0, 0, 0);
  endtask
  task automatic lookup(input logic [3:0] k, input logic [7:0] dflt);
    step(0, 0, 0, 0, 0, 0, 1, k, dflt);
  endtask
  task automatic wipe();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_hit", {31'd0, out_hit}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_wr_drop", {31'd0, wr_drop}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset then lookup
    lookup(3, 8'hEE);

    // Insert, update, back-to-back lookups
    wr(1, 8'h11); wr(2, 8'h22); wr(1, 8'h55);
    lookup(1, 8'h00); lookup(2, 8'h00); lookup(7, 8'hA5);

    // Full table and refused insert, then update while full
    wipe();
    for (int k = 1; k <= 4; k++) wr(4'(k), 8'(k * 16));
    wr(5, 8'h99); wr(6, 8'h98);
    lookup(5, 8'h3C);
    wr(3, 8'h77);
    lookup(3, 8'h00);

    // Delete and reuse
    step(0, 0, 0, 0, 1, 2, 0, 0, 0);
    wr(9, 8'h90);
    lookup(9, 8'h01); lookup(2, 8'h02);

    // Same-cycle hazards
    step(0, 0, 0, 0, 1, 9, 0, 0, 0);
    step(0, 1, 6, 8'h66, 0, 0, 1, 6, 8'hC3);
    lookup(6, 8'h00);
    step(0, 0, 0, 0, 1, 1, 1, 1, 8'h5A);
    lookup(1, 8'h5B);
    step(0, 1, 8, 8'h88, 1, 4, 1, 4, 8'h00);
    step(1, 1, 7, 8'h71, 0, 0, 1, 3, 8'h00);
    lookup(7, 8'h17); lookup(3, 8'h33);

    // Randomized traffic on a small key space to exercise hits, full and drops
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)),
           8'($urandom), $urandom_range(0, 2) == 0, 4'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, 4'($urandom_range(0, 7)), 8'($urandom));
    end

    // Async reset mid-stream
    for (int k = 1; k <= 3; k++) wr(4'(k), 8'(8'hB0 + k));
    lookup(1, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_hit", {31'd0, out_hit}, 32'd0);
    chk("arst_out_data", {24'd0, out_data}, 32'd0);
    chk("arst_count", {29'd0, count}, 32'd0);
    chk("arst_full", {31'd0, full}, 32'd0);
    exp_q.delete();
    model.delete();
    last_exp = '0; exp_count = 0; exp_full = 1'b0; exp_drop = 1'b0;
    wr_en = 1; wr_key = 7; wr_data = 8'h7E;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) lookup(4'(k), 8'(8'hD0 + k));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muxkey_table.md
# muxkey_table

Programmable key-value lookup table. Successor to the combinational key-select mux: instead of a constant (key, data) list wired into a port, it holds up to NR_KEY entries in registers. Entries are inserted, updated and deleted at run time. Lookups are registered and return a hit flag plus either the matched data or a per-lookup default. It sits in the NPC datapath wherever a decode or remap table must change without re-synthesis, for example CSR remap or device-address decode.

## Interface
- NR_KEY, 4, number of table entries (≥2)
- KEY_LEN, 4, key width in bits
- DATA_LEN, 8, data width in bits
- CNT_W, $clog2(NR_KEY+1), width of the occupancy count (derived, do not override)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- clr  input  1  synchronous clear of all entries
- wr_en  input  1  insert/update request
- wr_key  input  KEY_LEN  key to insert/update
- wr_data  input  DATA_LEN  data for wr_key
- wr_drop  output  1  registered; pulses 1 cycle when an insert is refused because the table is full
- del_en  input  1  delete request
- del_key  input  KEY_LEN  key to delete
- lk_valid  input  1  lookup request
- lk_key  input  KEY_LEN  key to look up
- lk_default  input  DATA_LEN  value returned on a miss
- out_valid  output  1  lookup result valid (1 cycle after lk_valid)
- out_hit  output  1  lookup matched a valid entry
- out_data  output  DATA_LEN  matched data, or lk_default on a miss
- count  output  CNT_W  number of valid entries
- full  output  1  count == NR_KEY

## Operation
- State per entry i: valid[i], key[i], data[i]. Keys among valid entries are unique by construction.
- Command priority each cycle: clr > wr_en > del_en. A lower-priority request in the same cycle is ignored, not queued.
- clr: all valid cleared. count becomes 0 next cycle. wr_drop is 0.
- wr_en, key matches a valid entry: that entry's data is overwritten. count unchanged.
- wr_en, no match, free entry exists: the lowest-index free entry gets the key and data and becomes valid. count increments.
- wr_en, no match, table full: table unchanged. wr_drop=1 for the next cycle.
- wr_en that updates an existing key while full: accepted, no drop.
- del_en, key matches: that entry's valid is cleared and count decrements. No match: no-op.
- Freed slots are reused lowest-index first. Table order carries no meaning.
- Lookup: compare lk_key against all valid entries.
  - Hit: out_hit=1 and out_data is the entry data.
  - Miss: out_hit=0 and out_data is lk_default as sampled with lk_valid.
- When lk_valid=0: out_valid=0 next cycle. out_hit and out_data hold their previous values.
- count and full are registered and reflect table contents after the last edge.

## Timing
- Reset, asynchronous: all valid=0, count=0, full=0, wr_drop=0, out_valid=0, out_hit=0, out_data=0. key/data arrays need not be reset.
- rst deassertion mid-operation: any command presented in the cycle rst is high is lost.
- Lookup latency is 1 cycle. Fully pipelined: one lookup per cycle, back-to-back.
- Same-cycle lookup and modify: the lookup sees the table before that edge (read-before-write).
  - A lookup of a key being inserted this cycle misses.
  - A lookup of a key being deleted this cycle hits with the old data.
- A write/delete takes effect for lookups issued on the following cycle. count/full update on the same edge as the table.
- wr_drop is a single-cycle pulse per refused write. Back-to-back refused writes give consecutive pulses.
- No handshakes: every command is accepted or dropped in its cycle; there is no back-pressure.

## Test plan
Parameters for all scenarios: NR_KEY=4, KEY_LEN=4, DATA_LEN=8.

- **Reset then lookup:** after reset, lookup key 3 with default 0xEE -> next cycle out_valid=1, out_hit=0, out_data=0xEE; count=0.
- **Insert, update, lookup:** write (1,0x11), (2,0x22), then (1,0x55); lookup 1 and 2 back-to-back -> 0x55 hit, then 0x22 hit; count=2.
- **Full table:** fill keys 1–4, then write (5,0x99) -> wr_drop=1 for one cycle, full=1, count=4, lookup 5 misses. Then write (3,0x77) -> no drop, lookup 3 returns 0x77.
- **Delete and reuse:** with keys 1–4 held in slots 0–3, delete 2 then write (9,0x90) -> count 4→3→4, lookup 9 hits 0x90, lookup 2 misses.
- **Same-cycle hazards:**
  - Insert (6,0x66) and lookup 6 in the same cycle -> miss; lookup 6 on the next cycle -> hit.
  - Delete 1 and lookup 1 in the same cycle -> hit with the old data.
  - Assert clr and wr_en together -> table empty, count=0.
- **Async reset mid-stream:** assert rst between clock edges during a lookup stream -> outputs go to reset values immediately. Lookups after release all miss.
